// File: rtl/tile_indexer.sv
// tile_indexer: turns the raw vs/de/RGB pixel stream into an aligned, registered bundle of tile index, brightness weight and frame strobes.
// Optional feature macro TILE_IDX_LUMA_EN: weight from luma (2R+5G+B)>>3; when undefined, the weight is taken from G[7:5] only.

module tile_indexer #(
  parameter int BLKS_X = 16,
  parameter int BLKS_Y = 9,
  parameter int TILE_W = 120,
  parameter int TILE_H = 120
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [23:0] data_i,
  output logic [31:0] tile_o,
  output logic        vs_o,
  output logic        vs_r_o,
  output logic        de_o,
  output logic [2:0]  wd_o
);

  localparam int PX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int COL_W = $clog2(BLKS_X + 1);
  localparam int ROW_W = $clog2(BLKS_Y + 1);

  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(TILE_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(TILE_H - 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(BLKS_X);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(BLKS_Y);
  localparam logic [31:0]      ROW_STEP = 32'(BLKS_X);
  localparam logic [31:0]      SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic vs_q, de_q;
  logic vs_rise, de_fall, active, pix_valid;

  logic [PX_W-1:0]  px_q, px_d, cur_px;
  logic [PY_W-1:0]  py_q, py_d, cur_py;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [31:0]      base_q, base_d, cur_base;

  logic             s1_de, s1_vs, s1_oob;
  logic [COL_W-1:0] s1_col;
  logic [31:0]      s1_base;

`ifdef TILE_IDX_LUMA_EN
  logic [7:0]  red, grn, blu;
  logic [10:0] luma_sum;
  logic [10:0] s1_sum;

  assign red = data_i[23:16];
  assign grn = data_i[15:8];
  assign blu = data_i[7:0];
  assign luma_sum = {2'b00, red, 1'b0} + {1'b0, grn, 2'b00} + {3'b000, grn} + {3'b000, blu};
`else
  logic [2:0] grn_hi;
  logic [2:0] s1_wd;

  assign grn_hi = 3'(data_i >> 13);
`endif

  assign vs_rise   = vs_i & ~vs_q;
  assign de_fall   = ~de_i & de_q;
  assign active    = (state_q == ACTIVE) || vs_rise;
  assign pix_valid = de_i && active;

  // A vs rising edge zeroes the position seen by this very cycle, so a
  // coincident pixel lands at the origin and a coincident de fall is discarded.
  assign cur_px   = vs_rise ? '0 : px_q;
  assign cur_py   = vs_rise ? '0 : py_q;
  assign cur_col  = vs_rise ? '0 : col_q;
  assign cur_row  = vs_rise ? '0 : row_q;
  assign cur_base = vs_rise ? '0 : base_q;

  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && vs_rise) begin
      state_d = ACTIVE;
    end
  end

  always_comb begin
    px_d   = cur_px;
    py_d   = cur_py;
    col_d  = cur_col;
    row_d  = cur_row;
    base_d = cur_base;
    if (active) begin
      if (de_i) begin
        if (cur_px == PX_LAST) begin
          px_d = '0;
          if (cur_col != COL_END) begin
            col_d = cur_col + 1'b1;
          end
        end else begin
          px_d = cur_px + 1'b1;
        end
      end else if (de_fall && !vs_rise) begin
        px_d  = '0;
        col_d = '0;
        if (cur_py == PY_LAST) begin
          py_d = '0;
          // Row base tracks row*BLKS_X so the index needs only one adder.
          if (cur_row != ROW_END) begin
            row_d  = cur_row + 1'b1;
            base_d = cur_base + ROW_STEP;
          end
        end else begin
          py_d = cur_py + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SYNC;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_i;
      de_q    <= de_i;
      px_q    <= px_d;
      py_q    <= py_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_de   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_oob  <= 1'b0;
      s1_col  <= '0;
      s1_base <= '0;
`ifdef TILE_IDX_LUMA_EN
      s1_sum  <= '0;
`else
      s1_wd   <= '0;
`endif
    end else begin
      s1_de   <= pix_valid;
      s1_vs   <= vs_i;
      s1_oob  <= (cur_col == COL_END) || (cur_row == ROW_END);
      s1_col  <= cur_col;
      s1_base <= cur_base;
`ifdef TILE_IDX_LUMA_EN
      s1_sum  <= luma_sum;
`else
      s1_wd   <= grn_hi;
`endif
    end
  end

  // Output stage: everything that leaves the block is registered and aligned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tile_o <= '0;
      de_o   <= 1'b0;
      wd_o   <= '0;
      vs_o   <= 1'b0;
      vs_r_o <= 1'b0;
    end else begin
      de_o   <= s1_de;
      vs_o   <= s1_vs;
      vs_r_o <= vs_o;
      if (!s1_de) begin
        tile_o <= '0;
      end else if (s1_oob) begin
        tile_o <= SENTINEL;
      end else begin
        tile_o <= s1_base + 32'(s1_col);
      end
`ifdef TILE_IDX_LUMA_EN
      wd_o <= s1_de ? 3'(s1_sum >> 8) : 3'd0;
`else
      wd_o <= s1_de ? s1_wd : 3'd0;
`endif
    end
  end

endmodule

// File: tb/tb_tile_indexer.sv
// Directed bench for tile_indexer on a 2x2 grid of 4x2-pixel tiles.
// Expected outputs are carried through a two-stage expectation pipeline matching the DUT latency.

module tb_tile_indexer;

  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        vs_i;
  logic        de_i;
  logic [23:0] data_i;
  logic [31:0] tile_o;
  logic        vs_o;
  logic        vs_r_o;
  logic        de_o;
  logic [2:0]  wd_o;

  int checks = 0;
  int failures = 0;

  logic        pDe, pVs, pVs2, pTileChk, inSync;
  logic [31:0] pTile;
  logic [2:0]  pWd;
  logic [23:0] pixData [4];
  logic [2:0]  pixWd [4];

  tile_indexer #(
    .BLKS_X(2),
    .BLKS_Y(2),
    .TILE_W(4),
    .TILE_H(2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vs_i  (vs_i),
    .de_i  (de_i),
    .data_i(data_i),
    .tile_o(tile_o),
    .vs_o  (vs_o),
    .vs_r_o(vs_r_o),
    .de_o  (de_o),
    .wd_o  (wd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: outputs seen after this edge belong to the inputs of the previous tick.
  task automatic tick(input logic eDe, input logic [31:0] eTile, input logic [2:0] eWd);
    @(posedge clk_i);
    #1;
    checkOutput("de_o", 32'(de_o), 32'(pDe));
    checkOutput("wd_o", 32'(wd_o), 32'(pWd));
    if (pTileChk) checkOutput("tile_o", tile_o, pTile);
    checkOutput("vs_o", 32'(vs_o), 32'(pVs));
    checkOutput("vs_r_o", 32'(vs_r_o), 32'(pVs2));
    pVs2     = pVs;
    pVs      = vs_i;
    pDe      = eDe;
    pTile    = eTile;
    pWd      = eWd;
    pTileChk = eDe || inSync;
  endtask

  task automatic idle(input int n);
    de_i   = 1'b0;
    data_i = 24'hFFFFFF;
    repeat (n) tick(1'b0, 32'd0, 3'd0);
  endtask

  task automatic drivePixels(input int n, input logic [31:0] t0, input logic [31:0] t1);
    logic [31:0] t;
    for (int p = 0; p < n; p++) begin
      if (p < 4) t = t0;
      else if (p < 8) t = t1;
      else t = SENT;
      de_i   = 1'b1;
      data_i = pixData[p % 4];
      tick(1'b1, t, pixWd[p % 4]);
    end
  endtask

  task automatic driveLine(input int n, input logic [31:0] t0, input logic [31:0] t1);
    drivePixels(n, t0, t1);
    idle(2);
  endtask

  task automatic vsPulse();
    vs_i = 1'b1;
    idle(2);
    vs_i = 1'b0;
    idle(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_de_o"}, 32'(de_o), 32'd0);
    checkOutput({tag, "_tile_o"}, tile_o, 32'd0);
    checkOutput({tag, "_wd_o"}, 32'(wd_o), 32'd0);
    checkOutput({tag, "_vs_o"}, 32'(vs_o), 32'd0);
    checkOutput({tag, "_vs_r_o"}, 32'(vs_r_o), 32'd0);
  endtask

  task automatic clearExpect();
    pDe = 1'b0; pVs = 1'b0; pVs2 = 1'b0;
    pTile = 32'd0; pWd = 3'd0; pTileChk = 1'b1;
  endtask

  initial begin
    pixData[0] = 24'hFFFFFF; pixWd[0] = 3'd7;
    pixData[1] = 24'h204020;
    pixData[2] = 24'hA0C060;
    pixData[3] = 24'h000000; pixWd[3] = 3'd0;
`ifdef TILE_IDX_LUMA_EN
    pixWd[1] = 3'd1;
    pixWd[2] = 3'd5;
`else
    pixWd[1] = 3'd2;
    pixWd[2] = 3'd6;
`endif
    rst_i = 1'b1; vs_i = 1'b0; de_i = 1'b0; data_i = 24'h0;
    inSync = 1'b1;
    clearExpect();
    #12;
    checkAllZero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // No vs edge yet: pixels must not produce de_o
    de_i = 1'b1; data_i = 24'hFFFFFF;
    repeat (3) tick(1'b0, 32'd0, 3'd0);
    idle(2);
    de_i = 1'b1;
    repeat (2) tick(1'b0, 32'd0, 3'd0);
    idle(3);

    // Full frame, then a long line and a line below the grid
    inSync = 1'b0;
    vsPulse();
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd2, 32'd3);
    driveLine(10, 32'd2, 32'd3);
    driveLine(8, SENT, SENT);

    // vs rise coinciding with a de falling edge
    drivePixels(3, SENT, SENT);
    vsPulse();
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd2, 32'd3);

    // Reset in the middle of line 2
    vsPulse();
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd0, 32'd1);
    drivePixels(3, 32'd2, 32'd3);
    #1;
    rst_i = 1'b1;
    #1;
    checkAllZero("midreset");
    de_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    inSync = 1'b1;
    clearExpect();
    de_i = 1'b1; data_i = 24'hFFFFFF;
    repeat (8) tick(1'b0, 32'd0, 3'd0);
    idle(2);

    // Restart; a one-pixel line still counts as a line
    inSync = 1'b0;
    vsPulse();
    driveLine(1, 32'd0, 32'd0);
    driveLine(8, 32'd0, 32'd1);
    driveLine(8, 32'd2, 32'd3);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_indexer.md
# tile_indexer

- Front end of the darkness-statistics path.
- Converts the raw pixel stream (vs/de/RGB) into the per-pixel tile index, 3-bit weight and frame strobes that the per-tile buffer bank consumes.
- Tracks raster position with counters rather than dividers, classifies each pixel's brightness, and presents everything as one aligned registered bundle.

## Interface
- `BLKS_X`, default 16: tile columns.
- `BLKS_Y`, default 9: tile rows.
- `TILE_W`, default 120: pixels per tile horizontally.
- `TILE_H`, default 120: lines per tile vertically.
- `clk_i` input, 1 bit: pixel clock.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `vs_i` input, 1 bit: vertical sync, active-high.
- `de_i` input, 1 bit: data enable, active-high.
- `data_i` input, 24 bits: pixel; R=[23:16], G=[15:8], B=[7:0].
- `tile_o` output, 32 bits: tile index, row*BLKS_X+col; 32'hFFFF_FFFF outside the grid.
- `vs_o` output, 1 bit: `vs_i` delayed to match the bundle.
- `vs_r_o` output, 1 bit: `vs_o` delayed one more cycle; `vs_o && !vs_r_o` marks the frame-start strobe.
- `de_o` output, 1 bit: qualified data enable.
- `wd_o` output, 3 bits: brightness weight.

## Operation
- States:
  - SYNC: entered at reset; `de_o` forced 0.
  - ACTIVE: entered on the first `vs_i` rising edge (`vs_i`=1 while the previous sample was 0).
- Returns to SYNC only by reset.
- Position counters:
  - `px` counts 0..TILE_W-1 and `col` counts 0..BLKS_X.
  - `py` counts 0..TILE_H-1 and `row` counts 0..BLKS_Y.
- Each `de_i`=1 cycle advances `px`. On wrap, `col` increments, saturating at BLKS_X.
- `de_i` falling edge:
  - clears `px` and `col`;
  - advances `py`; on wrap, `row` increments, saturating at BLKS_Y.
- `vs_i` rising edge clears all four counters. This takes priority over a simultaneous `de_i` edge.
- Tile index:
  - `col`==BLKS_X or `row`==BLKS_Y gives 32'hFFFF_FFFF;
  - otherwise row*BLKS_X+col, computed from a running row base register (adds BLKS_X per row wrap) with no multiplier.
- Pixels beyond the grid still propagate `de_o`=1 (in ACTIVE) with the sentinel index. Consumers ignore them.
- Weight: luma = (2R + 5G + B) >> 3, with an 11-bit sum and an 8-bit result. `wd_o` = luma[7:5].
- `de_i` inactive: `wd_o` = 0.

## Timing
- Reset values: all outputs 0, state SYNC, all counters 0, row base 0.
- Latency is 2 cycles for `tile_o`, `de_o`, `wd_o` and `vs_o`, all aligned:
  - stage 1 registers the counters and the luma sum;
  - stage 2 registers the outputs.
- `vs_r_o` is `vs_o` delayed 1 cycle, i.e. latency 3 from `vs_i`.
- The first `de_i` cycle of a frame yields `tile_o`=0 two cycles later.
- `de_i` high for only one cycle still counts one pixel and one line.
- Reset asserted mid-frame:
  - outputs clear immediately (asynchronously);
  - after release, no `de_o` until the next `vs_i` rising edge.
- Input counts exceeding the grid never wrap the index; the sentinel holds until the next line or frame clear.

## Configuration
- `TILE_IDX_LUMA_EN`:
  - defined: `wd_o` from luma as above (adders in stage 1);
  - undefined: `wd_o` = G[7:5] only, the adders are removed, and latency stays 2 (stage 1 just registers G).

## Test plan
Parameters for all scenarios: BLKS_X=2, BLKS_Y=2, TILE_W=4, TILE_H=2.
- Reset, then `de_i` pulses with no `vs_i` edge -> `de_o` stays 0, all outputs 0.
- `vs_i` 0->1 at cycle 10; 8-pixel lines ×4 -> `tile_o` sequence per line 0,0,0,0,1,1,1,1 for lines 0-1 and 2,2,2,2,3,3,3,3 for lines 2-3, each 2 cycles after `de_i`. `vs_o` rises at 12; `vs_r_o` rises at 13.
- 10-pixel line, then a 5th line -> pixels 8-9 and every pixel of line 4 give `tile_o`=32'hFFFF_FFFF with `de_o`=1.
- `data_i`=24'hFFFFFF -> `wd_o`=7 (luma 255). `data_i`=24'h204020 -> luma (64+320+32)>>3=52 -> `wd_o`=1. Without `TILE_IDX_LUMA_EN`: 24'h204020 -> `wd_o`=2.
- `rst_i` pulsed mid-line 2 -> outputs 0 the same cycle; no `de_o` until the next `vs_i` rise; next frame restarts at `tile_o`=0.
- `vs_i` rises in the same cycle as a `de_i` falling edge -> counters cleared, not advanced; next line starts at `tile_o`=0.
